// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Debounces a raw mechanical pushbutton and turns each accepted press and
// release into a single-cycle pulse. The raw level is first brought into the
// clock domain by a two-flop synchronizer. A four-state FSM then requires
// DEBOUNCE_CYCLES consecutive identical synchronized samples before it accepts
// a level change. press_pulse is intended to drive the T input of a downstream
// toggle flip-flop, so it must fire exactly once per physical press.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronized samples needed to accept a
//                    change (2..65535)
//   CNT_W            width of the stability counter
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset
//   btn_in         raw asynchronous button level (may bounce)
//   press_pulse    one-cycle pulse after an accepted press
//   release_pulse  one-cycle pulse after an accepted release
//   btn_level      debounced button level
//   busy           high while a candidate level change is being qualified
//   press_count    accepted presses, modulo 256
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       btn_level,
  output logic       busy,
  output logic [7:0] press_count
);

  // State encoding. The two WAIT states are the only ones with bit 0 set,
  // but the output decode below compares full codes for readability.
  localparam logic [1:0] IDLE      = 2'd0;  // stable low
  localparam logic [1:0] WAIT_HIGH = 2'd1;  // qualifying a rising change
  localparam logic [1:0] PRESSED   = 2'd2;  // stable high
  localparam logic [1:0] WAIT_LOW  = 2'd3;  // qualifying a falling change

  // Counter value on the sample that completes qualification. The entry
  // transition already counts as the first sample, hence the minus one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-flop synchronizer; only sync2_q (btn_s) may be used by the FSM.
  logic sync1_q;
  logic sync2_q;
  logic btn_s;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q,   count_d;

  assign btn_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!btn_s) begin
          // Bounce: discard the partial count, emit nothing.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = count_q + 8'd1;  // wraps 255 -> 0 naturally
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        // Staying here while held is what prevents auto-repeat.
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_LOW: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the values
    // from before this edge; blocking ones would let later lines see new values.
    // NOTE: reset sits inside the clocked block, so it only acts at a clock edge
    // and it overrides any transition, including one that would emit a pulse.
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;
  assign btn_level     = (state_q == PRESSED)   || (state_q == WAIT_LOW);
  assign busy          = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Directed-stimulus bench for btn_debounce_pulse (DEBOUNCE_CYCLES = 4).
// A behavioural model tracks the debounced level as "how many consecutive
// synchronized samples disagree with the current level"; reaching D flips the
// level and produces the matching pulse. A compare process checks every output
// against that model on each falling edge. Hand-computed literal checks at the
// key edges pin both the model and the DUT. A toggle flip-flop driven by
// press_pulse stands in for the downstream consumer.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       btn_level;
  logic       busy;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .btn_level    (btn_level),
    .busy         (busy),
    .press_count  (press_count)
  );

  // Downstream toggle flip-flop, T = press_pulse.
  logic tff_q;
  always @(posedge clk) begin
    if (reset)            tff_q <= 1'b0;
    else if (press_pulse) tff_q <= ~tff_q;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit [1:0] m_pipe;    // btn_in delayed by two edges; m_pipe[1] is what the FSM sees
  bit       m_level;
  int       m_run;     // consecutive samples disagreeing with m_level
  bit       m_press;
  bit       m_rel;
  int       m_count;
  bit       m_tff;
  bit       m_valid = 1'b0;

  always @(posedge clk) begin
    bit s;
    if (reset) begin
      m_pipe  = 2'b00;
      m_level = 1'b0;
      m_run   = 0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_count = 0;
      m_tff   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (m_press) m_tff = ~m_tff;   // the consumer sees last cycle's pulse
      s       = m_pipe[1];
      m_pipe  = {m_pipe[0], btn_in};
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = s;
          m_run   = 0;
          if (s) begin
            m_press = 1'b1;
            m_count = (m_count + 1) % 256;
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and event counters (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  int n_press = 0;
  int n_rel   = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("press_pulse",   32'(press_pulse),   32'(m_press));
      check("release_pulse", 32'(release_pulse), 32'(m_rel));
      check("btn_level",     32'(btn_level),     32'(m_level));
      check("busy",          32'(busy),          32'(m_run != 0));
      check("press_count",   32'(press_count),   32'(m_count));
      check("pulse_exclusive", 32'(press_pulse & release_pulse), 32'd0);
      check("toggle_q",      32'(tff_q),         32'(m_tff));
      if (press_pulse === 1'b1)   n_press++;
      if (release_pulse === 1'b1) n_rel++;
    end
  end

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic apply(input bit b, input bit r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) apply(b, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit bounce_hi [8];
    bit bounce_lo [8];
    int p0;
    int r0;
    bounce_hi = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bounce_lo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b1);
    check("rst_count", 32'(press_count), 32'd0);
    check("rst_level", 32'(btn_level),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    hold(1'b0, 3);

    // Clean press: pulse only after edge 6.
    p0 = n_press;
    for (int k = 1; k <= 8; k++) begin
      apply(1'b1, 1'b0);
      if (k == 5) check("clean_e5_no_pulse", 32'(press_pulse), 32'd0);
      if (k == 6) begin
        check("clean_e6_pulse",       32'(press_pulse), 32'd1);
        check("clean_e6_model_pulse", 32'(m_press),     32'd1);
        check("clean_e6_count",       32'(press_count), 32'd1);
      end
      if (k == 7) begin
        check("clean_e7_pulse_gone", 32'(press_pulse), 32'd0);
        check("clean_e7_level",      32'(btn_level),   32'd1);
      end
    end

    // Long hold: no auto-repeat.
    hold(1'b1, 20);
    check("hold_single_press", 32'(n_press - p0), 32'd1);

    // Release: pulse after edge 6, count unchanged.
    for (int k = 1; k <= 8; k++) begin
      apply(1'b0, 1'b0);
      if (k == 5) check("rel_e5_no_pulse", 32'(release_pulse), 32'd0);
      if (k == 6) begin
        check("rel_e6_pulse",       32'(release_pulse), 32'd1);
        check("rel_e6_model_pulse", 32'(m_rel),         32'd1);
      end
    end
    check("rel_level", 32'(btn_level),   32'd0);
    check("rel_count", 32'(press_count), 32'd1);

    // Bounce on press: 1,1,0,1,1,1,1,1 -> pulse after edge 9 only.
    p0 = n_press;
    for (int k = 1; k <= 12; k++) begin
      apply((k <= 8) ? bounce_hi[k-1] : 1'b1, 1'b0);
      if (k == 8) begin
        check("bounce_e8_no_pulse", 32'(press_pulse),   32'd0);
        check("bounce_e8_no_event", 32'(n_press - p0),  32'd0);
      end
      if (k == 9) begin
        check("bounce_e9_pulse",       32'(press_pulse), 32'd1);
        check("bounce_e9_model_pulse", 32'(m_press),     32'd1);
      end
    end
    check("bounce_single_press", 32'(n_press - p0), 32'd1);

    // Bounce on release: 0,0,1,0,0,0,0,0 -> release after edge 9, no extra press.
    p0 = n_press;
    r0 = n_rel;
    for (int k = 1; k <= 12; k++) begin
      apply((k <= 8) ? bounce_lo[k-1] : 1'b0, 1'b0);
      if (k == 8) check("rbounce_e8_no_pulse", 32'(release_pulse), 32'd0);
      if (k == 9) check("rbounce_e9_pulse",    32'(release_pulse), 32'd1);
    end
    check("rbounce_no_press",    32'(n_press - p0), 32'd0);
    check("rbounce_one_release", 32'(n_rel - r0),   32'd1);

    // Reset mid-qualification (WAIT_HIGH, cnt=2 after edge 4).
    hold(1'b0, 4);
    hold(1'b1, 4);
    check("midq_busy_before_rst", 32'(busy), 32'd1);
    apply(1'b1, 1'b1);
    check("midq_rst_pulse", 32'(press_pulse), 32'd0);
    check("midq_rst_level", 32'(btn_level),   32'd0);
    check("midq_rst_busy",  32'(busy),        32'd0);
    check("midq_rst_count", 32'(press_count), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      apply(1'b1, 1'b0);
      if (k == 5) check("midq_e5_no_pulse", 32'(press_pulse), 32'd0);
      if (k == 6) check("midq_e6_pulse",    32'(press_pulse), 32'd1);
    end
    hold(1'b0, 10);

    // Reset on the very edge that would qualify a press.
    p0 = n_press;
    hold(1'b1, 5);
    apply(1'b1, 1'b1);
    check("rst_edge_no_pulse", 32'(press_pulse), 32'd0);
    check("rst_edge_count",    32'(press_count), 32'd0);
    check("rst_edge_no_event", 32'(n_press - p0), 32'd0);
    hold(1'b1, 8);
    hold(1'b0, 10);

    // Wrap: 256 clean presses from a fresh reset.
    apply(1'b0, 1'b1);
    hold(1'b0, 3);
    p0 = n_press;
    r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      hold(1'b1, 7);
      if (i == 254) check("wrap_count_255", 32'(press_count), 32'd255);
      hold(1'b0, 7);
    end
    check("wrap_count_0",    32'(press_count),  32'd0);
    check("wrap_presses",    32'(n_press - p0), 32'd256);
    check("wrap_releases",   32'(n_rel - r0),   32'd256);
    check("wrap_toggle_q",   32'(tff_q),        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
